// File: rtl/switch_input_if.sv
// Switch-conditioner bus between the board pins / register file and
// switch_input. The slave modport is the conditioner; the master modport is
// whatever drives the raw pins and consumes the conditioned values.
//
// Go-event handshake: sw8_event rises on a debounced press of the go switch
// and stays high until the consumer holds sw_ack high across one rising clk
// edge. A press that lands on the acknowledge edge wins, so the event stays
// pending. sw_ack while no event is pending is ignored.
interface switch_input_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] sw_raw;
  logic             sw_ack;
  logic [WIDTH-1:0] sw_clean;
  logic             sw8_event;
  logic             sw8_overrun;
  logic             settling;
  logic [WIDTH-2:0] sw_snap;

  modport slave (
    input  sw_raw, sw_ack,
    output sw_clean, sw8_event, sw8_overrun, settling, sw_snap
  );

  modport master (
    output sw_raw, sw_ack,
    input  sw_clean, sw8_event, sw8_overrun, settling, sw_snap
  );
endinterface

// File: rtl/switch_input.sv
// switch_input: synchronises and debounces the board switches, presents a
// glitch-free sw_clean bus and raises a held go event on each debounced
// press of the top switch.
// Optional macro SWITCH_SNAPSHOT_EN: when defined, sw_snap is a register that
// captures the data switches at the moment of each go press; otherwise
// sw_snap is simply the live debounced data switches.
module switch_input #(
  parameter int WIDTH           = 9,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  switch_input_if.slave bus
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [CW-1:0]    count_q, count_d;
  logic             event_q, event_d;
  logic             overrun_q, overrun_d;
  logic             rise;

  // Two-flop synchroniser; s1 carries no logic so it can resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.sw_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM state, candidate, shared counter and debounced output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STABLE;
      cand_q  <= '0;
      count_q <= '0;
      clean_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      count_q <= count_d;
      clean_q <= clean_d;
    end
  end

  // Next state: any bit moving restarts the whole bus, so the bus only
  // updates as one coherent word after it has been quiet long enough.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    clean_d = clean_q;
    case (state_q)
      ST_STABLE: begin
        if (s2_q != clean_q) begin
          cand_d  = s2_q;
          count_d = '0;
          state_d = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        if (s2_q != cand_q) begin
          cand_d  = s2_q;
          count_d = '0;
        end else if (count_q == LAST) begin
          // A glitch that returned to the old value rewrites the same word.
          clean_d = cand_q;
          state_d = ST_STABLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  // Go press: top bit of sw_clean goes 0->1 on the edge being computed.
  assign rise = clean_d[WIDTH-1] & ~clean_q[WIDTH-1];

  // Event / overrun next state; a press on the ack edge keeps the event.
  always_comb begin
    event_d   = event_q;
    overrun_d = overrun_q;
    if (rise) begin
      event_d = 1'b1;
      if (event_q && !bus.sw_ack) overrun_d = 1'b1;
    end else if (bus.sw_ack) begin
      event_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Event and sticky overrun registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      event_q   <= event_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SWITCH_SNAPSHOT_EN
  logic [WIDTH-2:0] snap_q;

  // Capture the data switches written on the same edge as the go press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) snap_q <= '0;
    else if (rise) snap_q <= clean_d[WIDTH-2:0];
  end

  assign bus.sw_snap = snap_q;
`else
  assign bus.sw_snap = clean_q[WIDTH-2:0];
`endif

  assign bus.sw_clean    = clean_q;
  assign bus.sw8_event   = event_q;
  assign bus.sw8_overrun = overrun_q;
  assign bus.settling    = (state_q == ST_SETTLING);

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input with WIDTH=9, DEBOUNCE_CYCLES=4.
// Edge 1 is the first rising edge that samples a new sw_raw value; a held
// change shows on sw_clean right after edge 7.
module tb_switch_input;

  localparam int W = 9;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  switch_input_if #(.WIDTH(W)) bus ();

  switch_input #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and step past it to sample outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a value and wait well past the debounce latency.
  task automatic settle_to(input logic [W-1:0] v);
    bus.sw_raw = v;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.sw_raw = '0;
    bus.sw_ack = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.sw_clean !== 9'h000) begin
      bad++; $display("FAIL reset_clean: got %h expected %h", bus.sw_clean, 9'h000);
    end
    total++;
    if ({bus.sw8_event, bus.sw8_overrun, bus.settling} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b expected 000",
                      {bus.sw8_event, bus.sw8_overrun, bus.settling});
    end
    total++;
    if (bus.sw_snap !== 8'h00) begin
      bad++; $display("FAIL reset_snap: got %h expected %h", bus.sw_snap, 8'h00);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    logic [W-1:0] exp_clean;
    logic         exp_set;
    bus.sw_raw = 9'h0A5;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_clean = (e == 7) ? 9'h0A5 : 9'h000;
      exp_set   = (e >= 3 && e <= 6);
      total++;
      if (bus.sw_clean !== exp_clean) begin
        bad++; $display("FAIL latency_clean e%0d: got %h expected %h", e, bus.sw_clean, exp_clean);
      end
      total++;
      if (bus.settling !== exp_set) begin
        bad++; $display("FAIL latency_settling e%0d: got %b expected %b", e, bus.settling, exp_set);
      end
    end
    total++;
    if (bus.sw8_event !== 1'b0) begin
      bad++; $display("FAIL latency_event: got %b expected 0", bus.sw8_event);
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] exp_clean;
    settle_to(9'h0A4);
    total++;
    if (bus.sw_clean !== 9'h0A4) begin
      bad++; $display("FAIL glitch_base: got %h expected %h", bus.sw_clean, 9'h0A4);
    end
    for (int i = 0; i < 10; i++) begin
      bus.sw_raw[0] = ~bus.sw_raw[0];
      for (int k = 0; k < 2; k++) begin
        tick();
        total++;
        if (bus.sw_clean !== 9'h0A4) begin
          bad++; $display("FAIL glitch_hold i%0d: got %h expected %h", i, bus.sw_clean, 9'h0A4);
        end
      end
    end
    bus.sw_raw[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_clean = (e == 7) ? 9'h0A5 : 9'h0A4;
      total++;
      if (bus.sw_clean !== exp_clean) begin
        bad++; $display("FAIL glitch_final e%0d: got %h expected %h", e, bus.sw_clean, exp_clean);
      end
    end
  endtask

  task automatic test_event();
    logic exp_ev;
    bus.sw_raw = 9'h100;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_ev = (e == 7);
      total++;
      if (bus.sw8_event !== exp_ev) begin
        bad++; $display("FAIL event_rise e%0d: got %b expected %b", e, bus.sw8_event, exp_ev);
      end
      total++;
      if (bus.sw_clean[8] !== exp_ev) begin
        bad++; $display("FAIL event_clean8 e%0d: got %b expected %b", e, bus.sw_clean[8], exp_ev);
      end
    end
    repeat (3) tick();
    total++;
    if (bus.sw8_event !== 1'b1) begin
      bad++; $display("FAIL event_held: got %b expected 1", bus.sw8_event);
    end
    bus.sw_ack = 1'b1;
    tick();
    bus.sw_ack = 1'b0;
    total++;
    if ({bus.sw8_event, bus.sw8_overrun} !== 2'b00) begin
      bad++; $display("FAIL event_ack: got %b expected 00", {bus.sw8_event, bus.sw8_overrun});
    end
  endtask

  task automatic test_overrun();
    settle_to(9'h000);
    total++;
    if (bus.sw8_event !== 1'b0) begin
      bad++; $display("FAIL release_no_event: got %b expected 0", bus.sw8_event);
    end
    settle_to(9'h100);
    total++;
    if ({bus.sw8_event, bus.sw8_overrun} !== 2'b10) begin
      bad++; $display("FAIL press1: got %b expected 10", {bus.sw8_event, bus.sw8_overrun});
    end
    settle_to(9'h000);
    bus.sw_raw = 9'h100;
    repeat (6) tick();
    total++;
    if (bus.sw8_overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_early: got %b expected 0", bus.sw8_overrun);
    end
    tick();
    total++;
    if ({bus.sw8_event, bus.sw8_overrun} !== 2'b11) begin
      bad++; $display("FAIL press2_overrun: got %b expected 11", {bus.sw8_event, bus.sw8_overrun});
    end
    bus.sw_ack = 1'b1;
    tick();
    bus.sw_ack = 1'b0;
    total++;
    if ({bus.sw8_event, bus.sw8_overrun} !== 2'b00) begin
      bad++; $display("FAIL overrun_ack: got %b expected 00", {bus.sw8_event, bus.sw8_overrun});
    end
    // Ack with nothing pending must leave everything idle.
    bus.sw_ack = 1'b1;
    tick();
    bus.sw_ack = 1'b0;
    tick();
    total++;
    if ({bus.sw8_event, bus.sw8_overrun} !== 2'b00) begin
      bad++; $display("FAIL idle_ack: got %b expected 00", {bus.sw8_event, bus.sw8_overrun});
    end
    // Ack landing on the rise edge: press wins.
    settle_to(9'h000);
    bus.sw_raw = 9'h100;
    repeat (6) tick();
    bus.sw_ack = 1'b1;
    tick();
    bus.sw_ack = 1'b0;
    total++;
    if ({bus.sw8_event, bus.sw8_overrun} !== 2'b10) begin
      bad++; $display("FAIL ack_on_rise: got %b expected 10", {bus.sw8_event, bus.sw8_overrun});
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] exp_clean;
    bus.sw_raw = 9'h1FF;
    repeat (4) tick();
    total++;
    if (bus.settling !== 1'b1) begin
      bad++; $display("FAIL midsettle_settling: got %b expected 1", bus.settling);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.sw_clean !== 9'h000) begin
      bad++; $display("FAIL async_clean: got %h expected %h", bus.sw_clean, 9'h000);
    end
    total++;
    if ({bus.sw8_event, bus.sw8_overrun, bus.settling} !== 3'b000) begin
      bad++; $display("FAIL async_flags: got %b expected 000",
                      {bus.sw8_event, bus.sw8_overrun, bus.settling});
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_clean = (e == 7) ? 9'h1FF : 9'h000;
      total++;
      if (bus.sw_clean !== exp_clean) begin
        bad++; $display("FAIL postreset_clean e%0d: got %h expected %h", e, bus.sw_clean, exp_clean);
      end
    end
    total++;
    if (bus.sw8_event !== 1'b1) begin
      bad++; $display("FAIL postreset_event: got %b expected 1", bus.sw8_event);
    end
  endtask

  task automatic test_snapshot();
    logic [W-2:0] exp_snap;
    bus.sw_ack = 1'b1;
    tick();
    bus.sw_ack = 1'b0;
    settle_to(9'h03C);
    settle_to(9'h13C);
    total++;
    if (bus.sw_snap !== 8'h3C) begin
      bad++; $display("FAIL snap_at_press: got %h expected %h", bus.sw_snap, 8'h3C);
    end
    total++;
    if (bus.sw8_event !== 1'b1) begin
      bad++; $display("FAIL snap_event: got %b expected 1", bus.sw8_event);
    end
    settle_to(9'h0FF);
`ifdef SWITCH_SNAPSHOT_EN
    exp_snap = 8'h3C;
`else
    exp_snap = 8'hFF;
`endif
    total++;
    if (bus.sw_clean !== 9'h0FF) begin
      bad++; $display("FAIL snap_clean: got %h expected %h", bus.sw_clean, 9'h0FF);
    end
    total++;
    if (bus.sw_snap !== exp_snap) begin
      bad++; $display("FAIL snap_after_change: got %h expected %h", bus.sw_snap, exp_snap);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_event();
    test_overrun();
    test_async_reset();
    test_snapshot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
